// File: rtl/csr_packer_pkg.sv
// rtl/csr_packer_pkg.sv - shared constants, types and plane slicing for the coefficient register pair
package csr_packer_pkg;

  localparam int CSR_N = 4;
  localparam int CSR_W = 2;

  typedef logic [CSR_W-1:0] coef_t;
  typedef logic [CSR_N-1:0] plane_t;

  // Low index of bit-plane k inside a packed N*W word: plane(k) = [k*n +: n]
  function automatic int plane(input int k, input int n = CSR_N);
    return k * n;
  endfunction

endpackage

// File: rtl/csr_plane_slice.sv
// rtl/csr_plane_slice.sv - one bit plane: write-by-index fill register plus loadable output register
module csr_plane_slice
  import csr_packer_pkg::*;
#(
  parameter int N  = CSR_N,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_idx,
  input  logic          wr_bit,
  input  logic          load,
  output logic [N-1:0]  plane_q
);

  logic [N-1:0] acc;
  logic [N-1:0] acc_next;

  always_comb begin
    acc_next         = acc;
    acc_next[wr_idx] = wr_bit;
  end

  // The output load sees the bit being written this cycle, so the completing
  // coefficient lands in the frame on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      plane_q <= '0;
    end else begin
      if (wr_en) acc <= acc_next;
      if (load)  plane_q <= acc_next;
    end
  end

endmodule

// File: rtl/csr_packer.sv
// rtl/csr_packer.sv - packs a serial coefficient stream into W bit-plane words with a one-frame holding buffer
module csr_packer
  import csr_packer_pkg::*;
#(
  parameter int N  = CSR_N,
  parameter int W  = CSR_W,
  parameter int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic [W-1:0]   coef_in,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N*W-1:0] planes,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CW-1:0]  fill_cnt
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic run;
  logic last;
  logic accept;
  logic complete;

  // Only the frame-completing coefficient can stall, and only on a full, non-draining buffer.
  assign last     = (fill_cnt == LAST);
  assign in_ready = run & (~last | ~out_valid | out_ready);
  assign accept   = in_valid & in_ready & ~clear;
  assign complete = accept & last;

  for (genvar k = 0; k < W; k++) begin : g_plane
    csr_plane_slice #(
      .N  (N),
      .CW (CW)
    ) u_slice (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (accept),
      .wr_idx  (fill_cnt),
      .wr_bit  (coef_in[k]),
      .load    (complete),
      .plane_q (planes[plane(k, N) +: N])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run       <= 1'b0;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      run <= 1'b1;
      if (clear)         fill_cnt <= '0;
      else if (complete) fill_cnt <= '0;
      else if (accept)   fill_cnt <= fill_cnt + 1'b1;
      if (complete)                   out_valid <= 1'b1;
      else if (out_valid & out_ready) out_valid <= 1'b0;
    end
  end

endmodule
